// File: rtl/decimator_accum_if.sv
// Sample/result bundle for decimator_accum: enable, rate/mode control, input sample and decimated output.
interface decimator_accum_if #(
  parameter int DATA_WIDTH = 8,
  parameter int RATE_WIDTH = 8
);
  logic                             en;
  logic [RATE_WIDTH-1:0]            rate_i;
  logic                             mode_i;
  logic [DATA_WIDTH-1:0]            data_in;
  logic                             data_in_valid;
  logic                             data_valid;
  logic [DATA_WIDTH+RATE_WIDTH-1:0] data_out;

  modport master (
    output en, rate_i, mode_i, data_in, data_in_valid,
    input  data_valid, data_out
  );

  modport slave (
    input  en, rate_i, mode_i, data_in, data_in_valid,
    output data_valid, data_out
  );
endinterface

// File: rtl/decimator_accum.sv
// Runtime-rate decimator: pick last sample of each R-sample frame, or sum the frame.
// Sum mode is only built when DECIMATOR_ACCUM_SUM_EN is defined; otherwise pick mode is fixed.
module decimator_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int RATE_WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  decimator_accum_if.slave bus
);
  localparam int OUT_W = DATA_WIDTH + RATE_WIDTH;

  logic                  w_accept;
  logic                  w_first;
  logic                  w_last;
  logic [RATE_WIDTH-1:0] w_rate_in;
  logic [RATE_WIDTH-1:0] w_reff;
  logic [OUT_W-1:0]      w_sample;
  logic [OUT_W-1:0]      w_result;

  logic [RATE_WIDTH-1:0] r_cnt;
  logic [RATE_WIDTH-1:0] r_rate;
  logic [OUT_W-1:0]      r_data_out_p1;
  logic                  r_vld_p1;

  function automatic logic [OUT_W-1:0] zext(input logic [DATA_WIDTH-1:0] d);
    return {{RATE_WIDTH{1'b0}}, d};
  endfunction

  assign w_accept  = bus.en & bus.data_in_valid;
  assign w_first   = (r_cnt == '0);
  assign w_rate_in = (bus.rate_i == '0) ? RATE_WIDTH'(1) : bus.rate_i;
  // The first accept of a frame sees the live rate so R=1 closes the frame immediately.
  assign w_reff    = w_first ? w_rate_in : r_rate;
  assign w_last    = (r_cnt == w_reff - RATE_WIDTH'(1));
  assign w_sample  = zext(bus.data_in);

`ifdef DECIMATOR_ACCUM_SUM_EN
  logic             r_mode;
  logic [OUT_W-1:0] r_acc;
  logic             w_mode;
  logic [OUT_W-1:0] w_sum;

  // Output is wide enough for (2^RATE_WIDTH-1) full-scale samples, so plain addition never wraps.
  function automatic logic [OUT_W-1:0] acc_add(input logic [OUT_W-1:0]      a,
                                               input logic [DATA_WIDTH-1:0] d);
    return a + zext(d);
  endfunction

  assign w_mode   = w_first ? bus.mode_i : r_mode;
  assign w_sum    = w_first ? w_sample : acc_add(r_acc, bus.data_in);
  assign w_result = w_mode ? w_sum : w_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_acc  <= '0;
    end else if (w_accept) begin
      if (w_first) r_mode <= bus.mode_i;
      r_acc <= w_sum;
    end
  end
`else
  assign w_result = w_sample;
`endif

  // Stage p0 -> p1: frame bookkeeping and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_rate        <= RATE_WIDTH'(1);
      r_data_out_p1 <= '0;
      r_vld_p1      <= 1'b0;
    end else begin
      r_vld_p1 <= w_accept & w_last;
      if (w_accept) begin
        if (w_first) r_rate <= w_rate_in;
        r_cnt <= w_last ? '0 : r_cnt + RATE_WIDTH'(1);
        if (w_last) r_data_out_p1 <= w_result;
      end
    end
  end

  assign bus.data_valid = r_vld_p1;
  assign bus.data_out   = r_data_out_p1;
endmodule

// File: tb/tb_decimator_accum.sv
// Randomized and directed bench for decimator_accum against a frame-queue reference model.
module tb_decimator_accum;
  localparam int DW = 8;
  localparam int RW = 4;
  localparam int OW = DW + RW;
`ifdef DECIMATOR_ACCUM_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decimator_accum_if #(.DATA_WIDTH(DW), .RATE_WIDTH(RW)) bus ();
  decimator_accum #(.DATA_WIDTH(DW), .RATE_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is the list of accepted samples; it closes when it holds R samples.
  int frame_q[$];
  int m_rate;
  bit m_mode;
  bit exp_vld;
  int exp_out;

  task automatic model_reset();
    frame_q.delete();
    exp_vld = 1'b0;
    exp_out = 0;
  endtask

  task automatic model_step(input bit acc, input int d, input int rate, input bit mode);
    exp_vld = 1'b0;
    if (acc) begin
      if (frame_q.size() == 0) begin
        m_rate = (rate == 0) ? 1 : rate;
        m_mode = SUM_EN ? mode : 1'b0;
      end
      frame_q.push_back(d);
      if (frame_q.size() == m_rate) begin
        exp_vld = 1'b1;
        if (m_mode) begin
          exp_out = 0;
          foreach (frame_q[i]) exp_out += frame_q[i];
        end else begin
          exp_out = frame_q[$];
        end
        frame_q.delete();
      end
    end
  endtask

  task automatic step(input bit e, input bit v, input int d, input int rate, input bit mode);
    bus.en            = e;
    bus.data_in_valid = v;
    bus.data_in       = DW'(d);
    bus.rate_i        = RW'(rate);
    bus.mode_i        = mode;
    @(posedge clk);
    model_step(e && v, d, rate, mode);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.data_in_valid = 1'b0; bus.data_in = '0; bus.rate_i = '0; bus.mode_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== OW'(0)) begin
      errors++;
      $display("FAIL reset_state: valid=%0b out=%0d, required valid=0 out=0", bus.data_valid, bus.data_out);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pick_ramp();
    int got[$];
    int want[4];
    want = '{3, 7, 11, 15};
    for (int i = 0; i < 16; i++) begin
      step(1, 1, i, 4, 0);
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL pick_ramp[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
      if (bus.data_valid === 1'b1) got.push_back(int'(bus.data_out));
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL pick_ramp_count: pulses=%0d, required 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] != want[k]) begin
          errors++;
          $display("FAIL pick_ramp_value[%0d]: out=%0d, required %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_sum_ramp();
    int got[$];
    int want[3];
    if (SUM_EN) want = '{6, 22, 38};
    else        want = '{3, 7, 11};
    for (int i = 0; i < 12; i++) begin
      step(1, 1, i, 4, 1);
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL sum_ramp[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
      if (bus.data_valid === 1'b1) got.push_back(int'(bus.data_out));
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL sum_ramp_count: pulses=%0d, required 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] != want[k]) begin
          errors++;
          $display("FAIL sum_ramp_value[%0d]: out=%0d, required %0d", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 8; i++) begin
      int d;
      d = int'($urandom_range(0, 255));
      step(1, 1, d, (i < 4) ? 0 : 1, 1'($urandom_range(0, 1)));
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== OW'(d)) begin
        errors++;
        $display("FAIL passthrough[%0d]: valid=%0b out=%0d, required valid=1 out=%0d", i, bus.data_valid, bus.data_out, d);
      end
    end
  endtask

  task automatic test_rate_change();
    int pulses[$];
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 20 + i, (i < 2) ? 4 : 2, 0);
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL rate_change[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
      if (bus.data_valid === 1'b1) pulses.push_back(i);
    end
    checks++;
    if (pulses.size() != 3 || pulses[0] != 3) begin
      errors++;
      $display("FAIL rate_change_timing: pulses=%0d first_at=%0d, required 3 pulses first_at=3", pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
  endtask

  task automatic test_overflow();
    int want;
    want = SUM_EN ? 3825 : 255;
    for (int i = 0; i < 15; i++) step(1, 1, 255, 15, 1);
    checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== OW'(want)) begin
      errors++;
      $display("FAIL overflow: valid=%0b out=%0d, required valid=1 out=%0d", bus.data_valid, bus.data_out, want);
    end
  endtask

  task automatic test_gaps();
    int d;
    int want;
    int pulse_at;
    want = SUM_EN ? 33 : 12;
    d = 10;
    pulse_at = -1;
    for (int i = 0; i < 7; i++) begin
      bit v;
      bit e;
      v = (i % 2 == 0);
      e = (i != 4);
      step(e, v, (v && e) ? d : int'($urandom_range(0, 255)), 3, 1);
      if (v && e) d++;
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL gaps[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
      if (bus.data_valid === 1'b1) pulse_at = i;
    end
    checks++;
    if (pulse_at != 6 || bus.data_out !== OW'(want)) begin
      errors++;
      $display("FAIL gaps_result: pulse_at=%0d out=%0d, required pulse_at=6 out=%0d", pulse_at, bus.data_out, want);
    end
  endtask

  task automatic test_reset_mid();
    int want;
    step(1, 1, 50, 4, 1);
    step(1, 1, 60, 4, 1);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== OW'(0)) begin
      errors++;
      $display("FAIL reset_mid_async: valid=%0b out=%0d, required valid=0 out=0", bus.data_valid, bus.data_out);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, i, 4, 1);
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
    end
    want = SUM_EN ? 10 : 4;
    checks++;
    if (bus.data_valid !== 1'b1 || bus.data_out !== OW'(want)) begin
      errors++;
      $display("FAIL reset_mid_frame: valid=%0b out=%0d, required valid=1 out=%0d", bus.data_valid, bus.data_out, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      checks++;
      if (bus.data_valid !== exp_vld || bus.data_out !== OW'(exp_out)) begin
        errors++;
        $display("FAIL random[%0d]: valid=%0b out=%0d, required valid=%0b out=%0d", i, bus.data_valid, bus.data_out, exp_vld, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pick_ramp();
    test_sum_ramp();
    test_passthrough();
    test_rate_change();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
